// File: rtl/cpu_trace_monitor.sv
// Trace capture for the single-cycle CPU: circular buffer, PC/forced trigger, post-trigger window, playback.
// Optional jump-to-self halt trigger enabled by defining TRACE_HALT_DETECT_EN.
module cpu_trace_monitor #(
  parameter int DW       = 32,
  parameter int DEPTH    = 16,
  parameter int POST     = 8,
  parameter int HALT_CNT = 4
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic [DW-1:0]              pc,
  input  logic [DW-1:0]              inst,
  input  logic [DW-1:0]              r,
  input  logic                       valid,
  input  logic                       arm,
  input  logic                       trig_en,
  input  logic [DW-1:0]              trig_pc,
  input  logic                       force_trig,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [DW-1:0]              rd_pc,
  output logic [DW-1:0]              rd_inst,
  output logic [DW-1:0]              rd_r,
  output logic                       rd_last,
  output logic [1:0]                 state,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       halt
);

  // state   | meaning
  // S_IDLE  | no capture, waiting for arm
  // S_ARMED | capturing into the ring, watching for a trigger
  // S_POST  | capturing the post-trigger window
  // S_DONE  | capture frozen, playback on rd_req
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t        st;
  logic [DW-1:0] mem_pc   [DEPTH];
  logic [DW-1:0] mem_inst [DEPTH];
  logic [DW-1:0] mem_r    [DEPTH];
  logic [AW-1:0] wptr, rptr, postcnt;
  logic [AW:0]   cnt;

  logic capturing, store, pc_hit, halt_hit, trig, rd_fire;

  assign capturing = (st == S_ARMED) || (st == S_POST);
  assign store     = capturing && valid && !arm;
  assign pc_hit    = valid && trig_en && (pc == trig_pc);
  assign trig      = pc_hit || force_trig || halt_hit;
  assign rd_fire   = (st == S_DONE) && rd_req && (cnt != '0);

`ifdef TRACE_HALT_DETECT_EN
  localparam int RW = $clog2(HALT_CNT + 1);

  logic [DW-1:0] prev_pc;
  logic          prev_ok;
  logic [RW-1:0] run;
  logic          halt_q;

  assign halt_hit = capturing && valid && prev_ok && (pc == prev_pc) && (run == RW'(HALT_CNT - 1));
  assign halt     = halt_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      prev_pc <= '0;
      prev_ok <= 1'b0;
      run     <= '0;
      halt_q  <= 1'b0;
    end else if (arm) begin
      prev_ok <= 1'b0;
      run     <= '0;
      halt_q  <= 1'b0;
    end else if (capturing && valid) begin
      prev_pc <= pc;
      prev_ok <= 1'b1;
      if (prev_ok && pc == prev_pc) begin
        if (run != RW'(HALT_CNT)) run <= run + 1'b1;
      end else begin
        run <= '0;
      end
      if (halt_hit) halt_q <= 1'b1;
    end
  end
`else
  assign halt_hit = 1'b0;
  assign halt     = 1'b0;
`endif

  // Buffer contents need no reset; cnt and the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_pc[wptr]   <= pc;
      mem_inst[wptr] <= inst;
      mem_r[wptr]    <= r;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      st       <= S_IDLE;
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      postcnt  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_pc    <= '0;
      rd_inst  <= '0;
      rd_r     <= '0;
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      if (arm) begin
        st      <= S_ARMED;
        wptr    <= '0;
        rptr    <= '0;
        cnt     <= '0;
        postcnt <= '0;
      end else begin
        case (st)
          S_IDLE: ;
          S_ARMED, S_POST: begin
            if (valid) begin
              wptr <= wptr + 1'b1;
              if (cnt == (AW+1)'(DEPTH)) rptr <= rptr + 1'b1;
              else                       cnt  <= cnt + 1'b1;
            end
            if (st == S_ARMED) begin
              if (trig) begin
                if (POST == 0) begin
                  st <= S_DONE;
                end else begin
                  st      <= S_POST;
                  postcnt <= AW'(POST);
                end
              end
            end else if (valid) begin
              postcnt <= postcnt - 1'b1;
              if (postcnt == AW'(1)) st <= S_DONE;
            end
          end
          S_DONE: begin
            // rd_last still high means the final entry went out last cycle.
            if (rd_last) begin
              st <= S_IDLE;
            end else if (rd_fire) begin
              rd_valid <= 1'b1;
              rd_last  <= (cnt == (AW+1)'(1));
              rd_pc    <= mem_pc[rptr];
              rd_inst  <= mem_inst[rptr];
              rd_r     <= mem_r[rptr];
              rptr     <= rptr + 1'b1;
              cnt      <= cnt - 1'b1;
            end
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

  assign state = st;
  assign count = cnt;

endmodule
